// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the I2C master byte sequencer.
package i2c_ctrl_pkg;

    localparam int unsigned PRESC_W       = 8;
    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned MIN_PRESCALER = 2;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_START      = 4'd1,
        ST_ADDR       = 4'd2,
        ST_ADDR_ACK   = 4'd3,
        ST_WDATA      = 4'd4,
        ST_WDATA_ACK  = 4'd5,
        ST_RDATA      = 4'd6,
        ST_RDATA_NACK = 4'd7,
        ST_STOP       = 4'd8
    } state_e;

endpackage

// File: rtl/i2c_phase_tick.sv
// Decodes mid-low (drive) and mid-high (sample) points of each SCL period
// from the clock generator's down-counter.
module i2c_phase_tick
    import i2c_ctrl_pkg::*;
(
    input  logic [PRESC_W-1:0] prescaler_i,
    input  logic [PRESC_W-1:0] counter_i,
    input  logic               scl_i,
    output logic               drive_tick_c,
    output logic               sample_tick_c
);

    logic [PRESC_W:0] half_w;
    logic [PRESC_W:0] sample_pt_w;

    // Sample point can exceed 8 bits for large P; such a point is never reached.
    assign half_w        = (PRESC_W+1)'(prescaler_i >> 1);
    assign sample_pt_w   = (PRESC_W+1)'(prescaler_i) + half_w;
    assign drive_tick_c  = ~scl_i && ((PRESC_W+1)'(counter_i) == half_w);
    assign sample_tick_c =  scl_i && ((PRESC_W+1)'(counter_i) == sample_pt_w);

endmodule

// File: rtl/i2c_master_ctrl_block.sv
// Byte-level I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP,
// pacing itself off the external SCL generator which it holds in reset when idle.
module i2c_master_ctrl_block
    import i2c_ctrl_pkg::*;
(
    input  logic               i2c_core_clock_i,
    input  logic               reset_bit_i,
    input  logic               start_i,
    input  logic               rw_i,
    input  logic [6:0]         addr_i,
    input  logic [7:0]         tx_data_i,
    input  logic [PRESC_W-1:0] prescaler_i,
    input  logic [PRESC_W-1:0] counter_detect_edge_i,
    input  logic               scl_i,
    input  logic               sda_i,
    output logic               clk_gen_reset_o,
    output logic               sda_oe_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               ack_error_o,
    output logic [7:0]         rx_data_o
);

    state_e             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [PRESC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic               drv_seen_q, drv_seen_d;
    logic               rw_q, rw_d;
    logic [6:0]         addr_q, addr_d;
    logic [7:0]         tx_q, tx_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               gen_rst_q, gen_rst_d;
    logic               sda_oe_q, sda_oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ack_err_q, ack_err_d;
    logic [7:0]         rx_q, rx_d;
    logic               drive_tick_c;
    logic               sample_tick_c;
    logic               last_bit_c;

    i2c_phase_tick u_phase_tick (
        .prescaler_i   (presc_q),
        .counter_i     (counter_detect_edge_i),
        .scl_i         (scl_i),
        .drive_tick_c  (drive_tick_c),
        .sample_tick_c (sample_tick_c)
    );

    assign last_bit_c = (bit_cnt_q == 3'(BITS_PER_BYTE - 1));

    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
        if (!reset_bit_i) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            drv_seen_q <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            tx_q       <= '0;
            presc_q    <= '0;
            gen_rst_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            rx_q       <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            drv_seen_q <= drv_seen_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            presc_q    <= presc_d;
            gen_rst_q  <= gen_rst_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            rx_q       <= rx_d;
        end
    end

    // A sample tick only counts once the drive tick of the same bit has been
    // seen; this skips the half high period that follows generator release.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        drv_seen_d = drv_seen_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        presc_d    = presc_q;
        gen_rst_d  = gen_rst_q;
        sda_oe_d   = sda_oe_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
        rx_d       = rx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && (prescaler_i >= PRESC_W'(MIN_PRESCALER))) begin
                    rw_d       = rw_i;
                    addr_d     = addr_i;
                    tx_d       = tx_data_i;
                    presc_d    = prescaler_i;
                    ack_err_d  = 1'b0;
                    sda_oe_d   = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (hold_cnt_q == presc_q - PRESC_W'(1)) begin
                    gen_rst_d  = 1'b1;
                    shift_d    = {addr_q, rw_q};
                    bit_cnt_d  = '0;
                    drv_seen_d = 1'b0;
                    state_d    = ST_ADDR;
                end else begin
                    hold_cnt_d = hold_cnt_q + PRESC_W'(1);
                end
            end
            ST_ADDR, ST_WDATA: begin
                if (drive_tick_c) begin
                    sda_oe_d   = ~shift_q[7];
                    drv_seen_d = 1'b1;
                end else if (sample_tick_c && drv_seen_q) begin
                    drv_seen_d = 1'b0;
                    shift_d    = {shift_q[6:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (last_bit_c) begin
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WDATA_ACK;
                    end
                end
            end
            ST_ADDR_ACK, ST_WDATA_ACK: begin
                if (drive_tick_c) begin
                    sda_oe_d   = 1'b0;
                    drv_seen_d = 1'b1;
                end else if (sample_tick_c && drv_seen_q) begin
                    drv_seen_d = 1'b0;
                    if (sda_i) begin
                        ack_err_d = 1'b1;
                        state_d   = ST_STOP;
                    end else if (state_q == ST_WDATA_ACK) begin
                        state_d = ST_STOP;
                    end else if (rw_q) begin
                        state_d = ST_RDATA;
                    end else begin
                        shift_d = tx_q;
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (drive_tick_c) begin
                    sda_oe_d   = 1'b0;
                    drv_seen_d = 1'b1;
                end else if (sample_tick_c && drv_seen_q) begin
                    drv_seen_d = 1'b0;
                    shift_d    = {shift_q[6:0], sda_i};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (last_bit_c) begin
                        state_d = ST_RDATA_NACK;
                    end
                end
            end
            ST_RDATA_NACK: begin
                if (drive_tick_c) begin
                    sda_oe_d   = 1'b0;
                    drv_seen_d = 1'b1;
                end else if (sample_tick_c && drv_seen_q) begin
                    drv_seen_d = 1'b0;
                    rx_d       = shift_q;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                // Pull low during SCL low, release during SCL high: STOP edge.
                if (drive_tick_c) begin
                    sda_oe_d   = 1'b1;
                    drv_seen_d = 1'b1;
                end else if (sample_tick_c && drv_seen_q) begin
                    drv_seen_d = 1'b0;
                    sda_oe_d   = 1'b0;
                    gen_rst_d  = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign clk_gen_reset_o = gen_rst_q;
    assign sda_oe_o        = sda_oe_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign ack_error_o     = ack_err_q;
    assign rx_data_o       = rx_q;

endmodule

// File: tb/tb_i2c_master_ctrl_block.sv
// Directed bench: SCL generator model, open-drain bus and a byte-level slave/monitor.
module tb_i2c_master_ctrl_block;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] tx_data;
    logic [7:0] presc;
    logic [7:0] gen_cnt;
    logic       scl;
    logic       sda_line;
    logic       clk_gen_rst;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rx_data;

    int         tb_p = 4;
    logic       slave_pull = 1'b0;
    logic       slave_ack_addr = 1'b1;
    logic       slave_ack_data = 1'b1;
    logic [7:0] slave_rd_byte = 8'h00;

    int         starts = 0, stops = 0, scl_rises = 0, done_pulses = 0;
    int         bit_idx = 0, byte_idx = 0;
    logic [7:0] cap = 8'h00;
    logic [7:0] bytes_q [4];
    logic       acks_q  [4];
    logic       prev_scl = 1'b1, prev_sda = 1'b1;

    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    i2c_master_ctrl_block dut (
        .i2c_core_clock_i      (clk),
        .reset_bit_i           (rst_n),
        .start_i               (start),
        .rw_i                  (rw),
        .addr_i                (addr),
        .tx_data_i             (tx_data),
        .prescaler_i           (presc),
        .counter_detect_edge_i (gen_cnt),
        .scl_i                 (scl),
        .sda_i                 (sda_line),
        .clk_gen_reset_o       (clk_gen_rst),
        .sda_oe_o              (sda_oe),
        .busy_o                (busy),
        .done_o                (done),
        .ack_error_o           (ack_err),
        .rx_data_o             (rx_data)
    );

    // Generator: counter held at 2P-1 in reset, SCL high for the upper half.
    always @(posedge clk) begin
        if (!clk_gen_rst)       gen_cnt <= 8'(2 * tb_p - 1);
        else if (gen_cnt == 0)  gen_cnt <= 8'(2 * tb_p - 1);
        else                    gen_cnt <= gen_cnt - 8'd1;
    end
    assign scl      = clk_gen_rst ? (gen_cnt >= 8'(tb_p)) : 1'b1;
    assign sda_line = ~(sda_oe | slave_pull);

    // Slave and bus monitor, evaluated away from the active edge.
    initial begin
        for (int i = 0; i < 4; i++) begin
            bytes_q[i] = 8'h00;
            acks_q[i]  = 1'b1;
        end
        forever begin
            @(negedge clk);
            if (done) done_pulses++;
            if (prev_scl && scl && prev_sda && !sda_line) begin
                starts++;
                bit_idx  = 0;
                byte_idx = 0;
                slave_pull = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    bytes_q[i] = 8'h00;
                    acks_q[i]  = 1'b1;
                end
            end else if (prev_scl && scl && !prev_sda && sda_line) begin
                stops++;
            end
            if (!prev_scl && scl) begin
                scl_rises++;
                if (byte_idx < 4) begin
                    if (bit_idx < 8) cap = {cap[6:0], sda_line};
                    else             acks_q[byte_idx] = sda_line;
                end
                bit_idx++;
                if (bit_idx == 9) begin
                    if (byte_idx < 4) bytes_q[byte_idx] = cap;
                    byte_idx++;
                    bit_idx = 0;
                end
            end
            if (prev_scl && !scl) begin
                slave_pull = 1'b0;
                if (bit_idx == 8 && byte_idx == 0)
                    slave_pull = slave_ack_addr;
                else if (bit_idx == 8 && byte_idx == 1 && !bytes_q[0][0])
                    slave_pull = slave_ack_data;
                else if (byte_idx == 1 && bytes_q[0][0] && !acks_q[0] && bit_idx < 8)
                    slave_pull = ~slave_rd_byte[3'(7 - bit_idx)];
            end
            prev_scl = scl;
            prev_sda = sda_line;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue_start(input logic r, input logic [6:0] a, input logic [7:0] d,
                               input int p);
        @(negedge clk);
        start   = 1'b1;
        rw      = r;
        addr    = a;
        tx_data = d;
        presc   = 8'(p);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) check_eq({tag, "_busy_with_done"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    int  s0, p0, r0, d0;
    bit  found;

    initial begin
        rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; tx_data = '0; presc = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", 32'({busy, done, ack_err, sda_oe, clk_gen_rst, rx_data}), 32'd0);
        check_eq("rst_scl_high", 32'(scl), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x50 / 0xA5, P=4, both ACKed
        tb_p = 4;
        s0 = starts; p0 = stops; r0 = scl_rises; d0 = done_pulses;
        issue_start(1'b0, 7'h50, 8'hA5, 4);
        check_eq("wr_busy_after_start", 32'(busy), 32'd1);
        check_eq("wr_sda_start", 32'(sda_oe), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("wr_gen_held_p_minus_1", 32'(clk_gen_rst), 32'd0);
        @(negedge clk);
        check_eq("wr_gen_release_at_p", 32'(clk_gen_rst), 32'd1);
        wait_done("wr");
        check_eq("wr_addr_byte", 32'(bytes_q[0]), 32'h A0);
        check_eq("wr_data_byte", 32'(bytes_q[1]), 32'h A5);
        check_eq("wr_ack_addr", 32'(acks_q[0]), 32'd0);
        check_eq("wr_ack_data", 32'(acks_q[1]), 32'd0);
        check_eq("wr_ack_error", 32'(ack_err), 32'd0);
        check_eq("wr_done_pulses", 32'(done_pulses - d0), 32'd1);
        check_eq("wr_starts", 32'(starts - s0), 32'd1);
        check_eq("wr_stops", 32'(stops - p0), 32'd1);
        check_eq("wr_scl_rises", 32'(scl_rises - r0), 32'd19);
        check_eq("wr_idle_bus", 32'({scl, sda_line, clk_gen_rst, busy}), 32'b1100);

        // Read 0x50, slave returns 0x3C
        slave_rd_byte = 8'h3C;
        s0 = starts; p0 = stops;
        issue_start(1'b1, 7'h50, 8'h00, 4);
        wait_done("rd");
        check_eq("rd_addr_byte", 32'(bytes_q[0]), 32'h A1);
        check_eq("rd_rx_data", 32'(rx_data), 32'h 3C);
        check_eq("rd_master_nack", 32'(acks_q[1]), 32'd1);
        check_eq("rd_stops", 32'(stops - p0), 32'd1);
        check_eq("rd_ack_error", 32'(ack_err), 32'd0);

        // Address NACK
        slave_ack_addr = 1'b0;
        p0 = stops; r0 = scl_rises;
        issue_start(1'b0, 7'h50, 8'hA5, 4);
        wait_done("nack");
        check_eq("nack_ack_error", 32'(ack_err), 32'd1);
        check_eq("nack_scl_rises", 32'(scl_rises - r0), 32'd10);
        check_eq("nack_stops", 32'(stops - p0), 32'd1);
        check_eq("nack_rx_held", 32'(rx_data), 32'h 3C);
        slave_ack_addr = 1'b1;

        // Prescaler below minimum is ignored
        issue_start(1'b0, 7'h12, 8'h34, 1);
        check_eq("p1_not_busy", 32'(busy), 32'd0);
        check_eq("p1_no_output_change", 32'({ack_err, sda_oe, clk_gen_rst}), 32'b100);

        // Start while busy is ignored; P=3
        tb_p = 3;
        s0 = starts;
        issue_start(1'b0, 7'h2B, 8'h96, 3);
        check_eq("busy_ack_err_cleared", 32'(ack_err), 32'd0);
        repeat (30) @(negedge clk);
        start = 1'b1; rw = 1'b1; addr = 7'h11; tx_data = 8'h00; presc = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy");
        check_eq("busy_addr_byte", 32'(bytes_q[0]), 32'h 56);
        check_eq("busy_data_byte", 32'(bytes_q[1]), 32'h 96);
        check_eq("busy_single_start", 32'(starts - s0), 32'd1);

        // Reset during WDATA bit 3, then a P=2 write
        tb_p = 4;
        issue_start(1'b0, 7'h50, 8'hA5, 4);
        found = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (byte_idx == 1 && bit_idx == 3) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("rst_reached_wdata_bit3", 32'(found), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_outputs", 32'({busy, done, ack_err, sda_oe, clk_gen_rst, rx_data}), 32'd0);
        check_eq("midrst_bus", 32'({scl, sda_line}), 32'b11);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tb_p = 2;
        s0 = starts; p0 = stops;
        issue_start(1'b0, 7'h7F, 8'h01, 2);
        wait_done("post");
        check_eq("post_addr_byte", 32'(bytes_q[0]), 32'h FE);
        check_eq("post_data_byte", 32'(bytes_q[1]), 32'h 01);
        check_eq("post_stops", 32'(stops - p0), 32'd1);
        check_eq("post_ack_error", 32'(ack_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
